renkon_psum_buf: RTL and testbench

- Partial-sum store on the far side of the accumulator's sum_old/sum_new loop: supplies sum_old per output position and writes back sum_new.
- Generates the accumulator's reset and out_en controls.
- One instance per accumulator lane. The controller sequences one pass per input channel over npix output positions.

---
 rtl/renkon_psum_buf.sv | 90 +++++++++
 tb/tb_renkon_psum_buf.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/renkon_psum_buf.sv
// renkon_psum_buf: per-lane partial-sum store feeding sum_old and capturing sum_new for the accumulator
module renkon_psum_buf #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 256,
    parameter int AWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     start,
    input  logic                     first,
    input  logic                     last,
    input  logic [AWIDTH-1:0]        npix,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] sum_new,
    output logic signed [DWIDTH-1:0] sum_old,
    output logic                     acc_reset,
    output logic                     out_en,
    output logic                     ready,
    output logic                     busy,
    output logic                     pass_done
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, PREF, RUN, DONE} state_t;

    state_t                    r_state, w_next;
    logic                      r_first, r_last, r_ready, r_busy, r_pass_done;
    logic [AWIDTH-1:0]         r_npix, r_ptr;
    logic signed [DWIDTH-1:0]  r_sum_old;
    logic signed [DWIDTH-1:0]  r_mem [DEPTH];
    logic                      w_wr, w_end;
    logic [IW-1:0]             w_rd_addr;

    // next state plus write/last-position decode; read runs one address ahead of write
    always_comb begin
        w_wr      = (r_state == RUN) && in_valid;
        w_end     = w_wr && (r_ptr == r_npix - AWIDTH'(1));
        w_rd_addr = IW'(r_ptr + AWIDTH'(1));
        w_next    = r_state;
        case (r_state)
            IDLE:    w_next = (start && npix != '0) ? PREF : IDLE;
            PREF:    w_next = RUN;
            RUN:     w_next = w_end ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end

    // control state, latched pass fields, pointer and prefetched sum_old
    always_ff @(posedge clk) begin
        if (xrst) begin
            r_state     <= IDLE;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_npix      <= '0;
            r_ptr       <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_pass_done <= 1'b0;
            r_sum_old   <= '0;
        end else begin
            r_state     <= w_next;
            r_ready     <= (w_next == RUN);
            r_busy      <= (w_next != IDLE);
            r_pass_done <= (r_state == DONE) || (r_state == IDLE && start && npix == '0);
            if (r_state == IDLE && start) begin
                r_first <= first;
                r_last  <= last;
                r_npix  <= npix;
                r_ptr   <= '0;
            end else if (w_wr) begin
                r_ptr <= r_ptr + AWIDTH'(1);
            end
            r_sum_old <= (r_state == PREF)             ? r_mem[0] :
                         (w_wr && !w_end)              ? r_mem[w_rd_addr] :
                         (r_state == RUN && !in_valid) ? r_sum_old : '0;
        end
    end

    // partial-sum storage; contents survive reset and are stale until a first pass
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_ptr[IW-1:0]] <= sum_new;
    end

    assign sum_old   = r_sum_old;
    assign ready     = r_ready;
    assign busy      = r_busy;
    assign pass_done = r_pass_done;
    assign acc_reset = r_first & r_ready;
    assign out_en    = r_last & r_ready & in_valid;
endmodule

// File: tb/tb_renkon_psum_buf.sv
// tb_renkon_psum_buf: directed self-checking bench for renkon_psum_buf
module tb_renkon_psum_buf;
    logic               clk, xrst, start, first, last, in_valid;
    logic [8:0]         npix;
    logic signed [15:0] sum_new, sum_old;
    logic               acc_reset, out_en, ready, busy, pass_done;

    int n_chk, n_fail;
    int model [256];
    bit ok [256];

    renkon_psum_buf #(.DWIDTH(16), .DEPTH(256), .AWIDTH(9)) dut (
        .clk(clk), .xrst(xrst), .start(start), .first(first), .last(last),
        .npix(npix), .in_valid(in_valid), .sum_new(sum_new), .sum_old(sum_old),
        .acc_reset(acc_reset), .out_en(out_en), .ready(ready), .busy(busy),
        .pass_done(pass_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input bit f, input bit l, input int n, input int base, input int step,
                            input logic [7:0] vpat, input int vlen, input bit poke);
        int  p, k;
        bit  v;
        start = 1'b1; first = f; last = l; npix = 9'(n); in_valid = 1'b0;
        cyc();
        start = 1'b0; first = !f; last = !l; npix = 9'd2;
        if (n == 0) begin
            #2;
            chk("zero_pass_done", pass_done, 1);
            chk("zero_busy", busy, 0);
            cyc();
            #2;
            chk("zero_pass_done_clr", pass_done, 0);
            chk("zero_busy_after", busy, 0);
            return;
        end
        in_valid = 1'b1; sum_new = 16'sh7ead;
        #2;
        chk("pref_ready", ready, 0);
        chk("pref_busy", busy, 1);
        chk("pref_acc_reset", acc_reset, 0);
        chk("pref_out_en", out_en, 0);
        cyc();
        p = 0;
        k = 0;
        while (p < n && k < 2000) begin
            v = vpat[k % vlen];
            in_valid = v;
            sum_new = 16'(base + step * p);
            start = poke && (k == 1);
            #2;
            chk("run_ready", ready, 1);
            chk("run_busy", busy, 1);
            chk("run_acc_reset", acc_reset, f);
            chk("run_out_en", out_en, l & v);
            if (!f && ok[p]) chk("run_sum_old", sum_old, model[p]);
            if (v) begin
                model[p] = int'(sum_new);
                ok[p] = 1'b1;
                p++;
            end
            k++;
            cyc();
        end
        start = 1'b0; in_valid = 1'b0;
        chk("stream_len", p, n);
        #2;
        chk("done_ready", ready, 0);
        chk("done_busy", busy, 1);
        chk("done_pass_done", pass_done, 0);
        chk("done_sum_old", sum_old, 0);
        cyc();
        #2;
        chk("pass_done", pass_done, 1);
        chk("pass_done_busy", busy, 0);
        cyc();
        #2;
        chk("pass_done_clr", pass_done, 0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        xrst = 1'b1; start = 1'b0; first = 1'b0; last = 1'b0; npix = '0;
        in_valid = 1'b0; sum_new = '0;
        cyc();
        cyc();
        #2;
        chk("rst_sum_old", sum_old, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pass_done", pass_done, 0);
        chk("rst_acc_reset", acc_reset, 0);
        chk("rst_out_en", out_en, 0);
        xrst = 1'b0;
        cyc();
        // single channel: 5,6,7,8, then read back while writing negative values
        run_pass(1, 1, 4, 5, 1, 8'h01, 1, 0);
        run_pass(0, 0, 4, -100, 0, 8'h01, 1, 0);
        // two-channel accumulate: 1,2,3 then totals 11,22,33 with out_en
        run_pass(1, 0, 3, 1, 1, 8'h01, 1, 0);
        run_pass(0, 1, 3, 11, 11, 8'h01, 1, 0);
        // stalled stream 1,0,0,1,0,1 reading 11,22,33
        run_pass(0, 0, 3, 40, 1, 8'h29, 6, 0);
        // npix=0 then npix=1 and readback of 0..1
        run_pass(0, 0, 0, 0, 0, 8'h01, 1, 0);
        run_pass(0, 0, 1, 70, 0, 8'h01, 1, 0);
        run_pass(0, 0, 2, 90, 1, 8'h01, 1, 0);
        // start pulsed mid-pass with npix=2 must not shorten the 5-position pass
        run_pass(1, 0, 5, 500, 3, 8'h01, 1, 1);
        run_pass(0, 0, 5, 600, 1, 8'h01, 1, 0);
        // full depth, then full readback including address 255
        run_pass(1, 0, 256, 1000, 1, 8'h01, 1, 0);
        run_pass(0, 0, 256, -2000, 5, 8'h01, 1, 0);
        // reset after 2 of 4 positions
        start = 1'b1; first = 1'b1; last = 1'b0; npix = 9'd4;
        cyc();
        start = 1'b0;
        cyc();
        in_valid = 1'b1; sum_new = 16'sd200;
        cyc();
        sum_new = 16'sd201;
        cyc();
        model[0] = 200; model[1] = 201;
        xrst = 1'b1; in_valid = 1'b0;
        cyc();
        #2;
        chk("mid_rst_sum_old", sum_old, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pass_done", pass_done, 0);
        chk("mid_rst_acc_reset", acc_reset, 0);
        chk("mid_rst_out_en", out_en, 0);
        xrst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            #2;
            chk("post_rst_pass_done", pass_done, 0);
            chk("post_rst_busy", busy, 0);
        end
        run_pass(0, 0, 2, 7, 1, 8'h01, 1, 0);
        run_pass(1, 1, 4, 300, 1, 8'h01, 1, 0);
        run_pass(0, 0, 4, 0, 0, 8'h01, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
